// File: rtl/q_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : q_reg_sequencer_if
// Brief  : Job/digit handshake bundle between Newton top, datapath and sequencer
// Rev    : 1.0  initial release
// ============================================================================
interface q_reg_sequencer_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [10:0]           num_digits;
    logic [ADDR_WIDTH-1:0] num_iters;
    logic                  q_valid;
    logic                  q_enable;
    logic                  q_refresh;
    logic [ADDR_WIDTH-1:0] accum;
    logic [10:0]           counter;
    logic [10:0]           shift_cnt;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, abort, base_addr, num_digits, num_iters, q_valid,
        input  q_enable, q_refresh, accum, counter, shift_cnt, busy, done, err
    );

    modport slave (
        input  start, abort, base_addr, num_digits, num_iters, q_valid,
        output q_enable, q_refresh, accum, counter, shift_cnt, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/q_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : q_reg_sequencer
// Brief  : Quotient-digit register bank sequencer; optional Q_SEQ_ERR_EN
//          builds the sticky overrun flag (otherwise err is tied low).
// Rev    : 1.0  initial release
// ============================================================================
module q_reg_sequencer #(
    parameter int UNROLLING    = 64,
    parameter int ONLINE_DELAY = 3,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic             clk,
    input  logic             asyn_reset_n,
    q_reg_sequencer_if.slave bus
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WARMUP = 3'd1;
    localparam logic [2:0] c_FIRST  = 3'd2;
    localparam logic [2:0] c_SHIFT  = 3'd3;
    localparam logic [2:0] c_NEXT   = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    localparam logic [10:0]           c_UNROLL     = 11'(UNROLLING);
    localparam logic [3:0]            c_DELAY      = 4'(ONLINE_DELAY);
    localparam int                    c_SHIFT_BASE = UNROLLING - 6;
    localparam logic [ADDR_WIDTH-1:0] c_A_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            state_q,   state_d;
    logic [3:0]            delay_q,   delay_d;
    logic [10:0]           digits_q,  digits_d;
    logic [10:0]           counter_q, counter_d;
    logic [10:0]           shift_q,   shift_d;
    logic [ADDR_WIDTH-1:0] accum_q,   accum_d;
    logic [ADDR_WIDTH-1:0] iters_q,   iters_d;
    logic [ADDR_WIDTH-1:0] iter_q,    iter_d;

    logic w_start_ok;
    logic w_last_digit;
    logic w_last_iter;

    assign w_start_ok   = bus.start & ~bus.abort & (state_q == c_IDLE);
    assign w_last_digit = (counter_q + 11'd1) == digits_q;
    assign w_last_iter  = iter_q == (iters_q - c_A_ONE);

    // FSM state register
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE:   if (bus.start) state_d = (ONLINE_DELAY == 0) ? c_FIRST : c_WARMUP;
                c_WARMUP: if (bus.q_valid && ((delay_q + 4'd1) == c_DELAY)) state_d = c_FIRST;
                c_FIRST:  if (bus.q_valid) state_d = (digits_q == 11'd1) ? c_NEXT : c_SHIFT;
                c_SHIFT:  if (bus.q_valid && w_last_digit) state_d = c_NEXT;
                c_NEXT:   state_d = w_last_iter ? c_DONE : c_FIRST;
                c_DONE:   state_d = c_IDLE;
                default:  state_d = c_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        bus.q_enable  = bus.q_valid & ~bus.abort & ((state_q == c_FIRST) | (state_q == c_SHIFT));
        bus.q_refresh = bus.q_valid & ~bus.abort & (state_q == c_FIRST);
        bus.busy      = (state_q != c_IDLE);
        bus.done      = (state_q == c_DONE) & ~bus.abort;
        bus.accum     = accum_q;
        bus.counter   = counter_q;
        bus.shift_cnt = shift_q;
    end

    // Job context and per-iteration counters
    always_comb begin
        delay_d   = delay_q;
        digits_d  = digits_q;
        counter_d = counter_q;
        accum_d   = accum_q;
        iters_d   = iters_q;
        iter_d    = iter_q;
        if (bus.abort) begin
            counter_d = 11'd0;
        end else begin
            case (state_q)
                c_IDLE: if (bus.start) begin
                    digits_d  = ((bus.num_digits == 11'd0) || (bus.num_digits > c_UNROLL))
                                ? c_UNROLL : bus.num_digits;
                    iters_d   = (bus.num_iters == '0) ? c_A_ONE : bus.num_iters;
                    accum_d   = bus.base_addr;
                    counter_d = 11'd0;
                    iter_d    = '0;
                    delay_d   = 4'd0;
                end
                c_WARMUP: if (bus.q_valid) delay_d = delay_q + 4'd1;
                c_FIRST:  if (bus.q_valid) counter_d = 11'd1;
                c_SHIFT:  if (bus.q_valid) counter_d = counter_q + 11'd1;
                c_NEXT: if (!w_last_iter) begin
                    accum_d   = accum_q + c_A_ONE;
                    iter_d    = iter_q + c_A_ONE;
                    counter_d = 11'd0;
                end
                default: ;
            endcase
        end
    end

    // Alignment shift tracks the counter value it will be paired with
    always_comb begin
        if (int'(counter_d) >= c_SHIFT_BASE) begin
            shift_d = 11'd0;
        end else begin
            shift_d = 11'(c_SHIFT_BASE - int'(counter_d));
        end
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            delay_q   <= 4'd0;
            digits_q  <= c_UNROLL;
            counter_q <= 11'd0;
            shift_q   <= 11'(c_SHIFT_BASE < 0 ? 0 : c_SHIFT_BASE);
            accum_q   <= '0;
            iters_q   <= c_A_ONE;
            iter_q    <= '0;
        end else begin
            delay_q   <= delay_d;
            digits_q  <= digits_d;
            counter_q <= counter_d;
            shift_q   <= shift_d;
            accum_q   <= accum_d;
            iters_q   <= iters_d;
            iter_q    <= iter_d;
        end
    end

`ifdef Q_SEQ_ERR_EN
    logic err_q, err_d;

    // A lost digit in NEXT or a start while busy flags an overrun until the next job
    always_comb begin
        err_d = err_q;
        if (w_start_ok) begin
            err_d = 1'b0;
        end else if (((state_q == c_NEXT) && bus.q_valid) || (bus.start && (state_q != c_IDLE))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/q_reg_sequencer.md
# q_reg_sequencer

Control FSM for the online-division quotient-digit register bank. Accepts a job (base address, digits per iteration, iteration count), discards the online-delay digits, then sequences `q_enable`, `q_refresh`, `accum`, `counter` and `shift_cnt` so that each Newton iteration's quotient digits accumulate in their own RAM slot. Sits between the digit-selection datapath (`q_valid`) and the q-digit register/RAM block, and signals job completion to the Newton top-level.

## Interface
- `UNROLLING`, 64: digit register width; maximum digits per iteration.
- `ONLINE_DELAY`, 3: leading digits discarded per job; legal range 0..15.
- `ADDR_WIDTH`, 7: RAM slot address width.
- `clk` in 1: clock, rising edge.
- `asyn_reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: job request; accepted only in IDLE.
- `abort` in 1: synchronous cancel; any state goes to IDLE.
- `base_addr` in ADDR_WIDTH: first RAM slot; latched on start.
- `num_digits` in 11: digits per iteration; latched on start.
- `num_iters` in ADDR_WIDTH: iterations per job; latched on start.
- `q_valid` in 1: datapath presents a digit this cycle.
- `q_enable` out 1: write strobe to the digit register.
- `q_refresh` out 1: first digit of an iteration; clears the shift register.
- `accum` out ADDR_WIDTH: current RAM slot.
- `counter` out 11: digits captured in the current iteration.
- `shift_cnt` out 11: alignment shift for the digit register.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky overrun flag; see Configuration.

## Operation
- States: IDLE, WARMUP, FIRST, SHIFT, NEXT, DONE.
- Latch on start:
  - `num_digits` = 0 is treated as UNROLLING; values above UNROLLING clamp to UNROLLING.
  - `num_iters` = 0 is treated as 1.
  - `accum` <= `base_addr`; `counter` <= 0; iteration index <= 0.
- IDLE: on `start`, go to WARMUP, or to FIRST if ONLINE_DELAY = 0.
- WARMUP: each `q_valid` increments the delay count. The `q_valid` that completes the ONLINE_DELAY-th discarded digit moves the FSM to FIRST. `q_enable` stays 0.
- FIRST: on `q_valid`, `q_enable` = `q_refresh` = 1 and `counter` <= 1. Go to SHIFT, or to NEXT if the digit count is 1.
- SHIFT: on `q_valid`, `q_enable` = 1 and `counter` <= `counter`+1. When `counter`+1 equals the digit count, go to NEXT.
- NEXT: one cycle with `q_enable` = 0.
  - Last iteration: go to DONE.
  - Otherwise: `accum` <= `accum`+1 (wraps modulo 2^ADDR_WIDTH), iteration index +1, `counter` <= 0, go to FIRST.
- DONE: `done` = 1 for one cycle, then go to IDLE. `accum` and `counter` hold their values in IDLE.
- `shift_cnt` is registered and equals max(0, UNROLLING−6−`counter`), updated together with `counter`.
- `q_enable` is combinational: `q_valid` AND (state is FIRST or SHIFT). `q_refresh` is combinational: `q_valid` AND state is FIRST.
- `busy` = 1 in every state except IDLE.
- `start` while busy is ignored.
- `abort` has priority over all transitions:
  - Next state is IDLE; `counter` <= 0; `accum` holds; no `done` pulse.
  - `q_enable` is forced to 0 in the abort cycle.
  - `abort` and `start` together in IDLE: FSM stays in IDLE.

## Timing
- Reset: FSM in IDLE; `accum`, `counter`, `busy`, `done`, `err` are 0; `shift_cnt` = UNROLLING−6.
- `start` sampled at edge N makes `busy` = 1 from cycle N+1.
- With `q_valid` held high, one job takes ONLINE_DELAY + iters·(digits+1) + 1 cycles from the first busy cycle until `done`, inclusive.
- Gaps in `q_valid` stall the FSM with all registers holding. NEXT and DONE do not wait for `q_valid`.
- `q_valid` in NEXT is dropped.

## Configuration
- `Q_SEQ_ERR_EN` defined:
  - `err` is set by `q_valid` in NEXT (digit lost) or by `start` while busy.
  - `err` is cleared when a start is accepted, and on reset.
- Macro undefined: `err` is tied to 0 and no error logic is built.

## Test plan
- Reset mid-SHIFT (assert `asyn_reset_n` low asynchronously) -> all outputs at reset values immediately; `shift_cnt` = 58.
- `start`, `base_addr`=5, `num_digits`=4, `num_iters`=1, `q_valid` high, start sampled at cycle 0:
  - WARMUP in cycles 1–3, with `q_enable` = 0.
  - Cycle 4: `q_refresh` = 1; `counter` reads 1 and `shift_cnt` 57 from cycle 5.
  - SHIFT in cycles 5–7; NEXT in cycle 8.
  - Cycle 9: `done` = 1; `busy` = 0 from cycle 10; `accum` = 5 throughout.
- `base_addr`=127, `num_iters`=3, `num_digits`=2 -> `accum` sequence 127, 0, 1; `q_refresh` pulses exactly 3 times; one `done` pulse.
- `num_digits`=4 with `q_valid` toggling 1,0,1,0,… -> `counter` increments only on valid cycles; the job takes 2× the digit cycles; `done` still asserted exactly once.
- `abort` at `counter`=2 -> IDLE next cycle; `counter` = 0, `accum` unchanged, no `done`.
- `start` during a job (macro defined) -> `err` = 1 and the job is unaffected.
- `q_valid` in NEXT (macro defined) -> `err` = 1; the next accepted start clears it.
